// File: rtl/obi_bridge_pipelined.sv
// Pipelined VX-to-OBI bridge: one request register, an in-order pending FIFO of
// {rw, tag} and a response FIFO of {rdata, tag}. Write completions are absorbed.
module obi_bridge_pipelined #(
    parameter int TAG_WIDTH_BIT   = 1,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               vx_req_valid_i,
    output logic                               vx_req_ready_o,
    input  logic                               vx_req_rw_i,
    input  logic [DATA_WIDTH/8-1:0]            vx_req_byteen_i,
    input  logic [ADDR_WIDTH-1:0]              vx_req_addr_i,
    input  logic [DATA_WIDTH-1:0]              vx_req_data_i,
    input  logic [TAG_WIDTH_BIT-1:0]           vx_req_tag_i,
    output logic                               vx_rsp_valid_o,
    input  logic                               vx_rsp_ready_i,
    output logic [DATA_WIDTH-1:0]              vx_rsp_data_o,
    output logic [TAG_WIDTH_BIT-1:0]           vx_rsp_tag_o,
    output logic                               obi_req_o,
    input  logic                               obi_gnt_i,
    output logic                               obi_we_o,
    output logic [DATA_WIDTH/8-1:0]            obi_be_o,
    output logic [ADDR_WIDTH-1:0]              obi_addr_o,
    output logic [DATA_WIDTH-1:0]              obi_wdata_o,
    input  logic                               obi_rvalid_i,
    input  logic [DATA_WIDTH-1:0]              obi_rdata_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                               protocol_err_o
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    // request register
    logic                     req_valid_q;
    logic                     req_we_q;
    logic [BE_W-1:0]          req_be_q;
    logic [ADDR_WIDTH-1:0]    req_addr_q;
    logic [DATA_WIDTH-1:0]    req_wdata_q;

    // pending FIFO
    logic                     pend_rw  [MAX_OUTSTANDING];
    logic [TAG_WIDTH_BIT-1:0] pend_tag [MAX_OUTSTANDING];
    logic [PTR_W:0]           pend_wr_q, pend_rd_q;

    // response FIFO
    logic [DATA_WIDTH-1:0]    rsp_data [MAX_OUTSTANDING];
    logic [TAG_WIDTH_BIT-1:0] rsp_tag  [MAX_OUTSTANDING];
    logic [PTR_W:0]           rsp_wr_q, rsp_rd_q;

    logic                     err_q;

    logic                     accept, grant, pend_empty, pend_pop, rsp_push, rsp_pop, rsp_nonempty;
    logic [PTR_W:0]           pend_cnt, rsp_cnt;
    logic [CNT_W-1:0]         occupancy;

    always_comb begin
        pend_cnt     = pend_wr_q - pend_rd_q;
        rsp_cnt      = rsp_wr_q - rsp_rd_q;
        occupancy    = CNT_W'(pend_cnt) + CNT_W'(rsp_cnt);
        pend_empty   = (pend_wr_q == pend_rd_q);
        rsp_nonempty = (rsp_wr_q != rsp_rd_q);

        vx_req_ready_o = !rst_i && (occupancy < CNT_W'(MAX_OUTSTANDING))
                         && (!req_valid_q || obi_gnt_i);
        accept   = vx_req_valid_i && vx_req_ready_o;
        grant    = req_valid_q && obi_gnt_i;
        // a stray rvalid with nothing pending is dropped and only flagged
        pend_pop = obi_rvalid_i && !pend_empty;
        rsp_push = pend_pop && !pend_rw[pend_rd_q[PTR_W-1:0]];
        rsp_pop  = rsp_nonempty && vx_rsp_ready_i;
    end

    assign obi_req_o      = req_valid_q;
    assign obi_we_o       = req_we_q;
    assign obi_be_o       = req_be_q;
    assign obi_addr_o     = req_addr_q;
    assign obi_wdata_o    = req_wdata_q;
    assign vx_rsp_valid_o = rsp_nonempty;
    assign vx_rsp_data_o  = rsp_nonempty ? rsp_data[rsp_rd_q[PTR_W-1:0]] : '0;
    assign vx_rsp_tag_o   = rsp_nonempty ? rsp_tag[rsp_rd_q[PTR_W-1:0]] : '0;
    assign outstanding_o  = occupancy;
    assign protocol_err_o = err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_valid_q <= 1'b0;
            req_we_q    <= 1'b0;
            req_be_q    <= '0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            pend_wr_q   <= '0;
            pend_rd_q   <= '0;
            rsp_wr_q    <= '0;
            rsp_rd_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            if (accept) begin
                req_valid_q <= 1'b1;
                req_we_q    <= vx_req_rw_i;
                req_be_q    <= vx_req_byteen_i;
                req_addr_q  <= vx_req_addr_i;
                req_wdata_q <= vx_req_data_i;
                pend_wr_q   <= pend_wr_q + 1'b1;
            end else if (grant) begin
                req_valid_q <= 1'b0;
            end
            if (pend_pop) pend_rd_q <= pend_rd_q + 1'b1;
            if (rsp_push) rsp_wr_q  <= rsp_wr_q + 1'b1;
            if (rsp_pop)  rsp_rd_q  <= rsp_rd_q + 1'b1;
            if (obi_rvalid_i && pend_empty) err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            pend_rw[pend_wr_q[PTR_W-1:0]]  <= vx_req_rw_i;
            pend_tag[pend_wr_q[PTR_W-1:0]] <= vx_req_tag_i;
        end
        if (rsp_push) begin
            rsp_data[rsp_wr_q[PTR_W-1:0]] <= obi_rdata_i;
            rsp_tag[rsp_wr_q[PTR_W-1:0]]  <= pend_tag[pend_rd_q[PTR_W-1:0]];
        end
    end

endmodule

// File: tb/tb_obi_bridge_pipelined.sv
// Directed bench for obi_bridge_pipelined: read, write, saturation, grant stall,
// ordering with a write in between, protocol error and reset mid-flight.
module tb_obi_bridge_pipelined;

    logic        clk = 1'b0;
    logic        rst;
    logic        vx_req_valid, vx_req_ready, vx_req_rw;
    logic [3:0]  vx_req_byteen;
    logic [31:0] vx_req_addr, vx_req_data;
    logic [0:0]  vx_req_tag;
    logic        vx_rsp_valid, vx_rsp_ready;
    logic [31:0] vx_rsp_data;
    logic [0:0]  vx_rsp_tag;
    logic        obi_req, obi_gnt, obi_we;
    logic [3:0]  obi_be;
    logic [31:0] obi_addr, obi_wdata, obi_rdata;
    logic        obi_rvalid;
    logic [2:0]  outstanding;
    logic        protocol_err;

    int n_checks = 0;
    int n_fail   = 0;

    obi_bridge_pipelined #(
        .TAG_WIDTH_BIT(1), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(4)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .vx_req_valid_i(vx_req_valid), .vx_req_ready_o(vx_req_ready),
        .vx_req_rw_i(vx_req_rw), .vx_req_byteen_i(vx_req_byteen),
        .vx_req_addr_i(vx_req_addr), .vx_req_data_i(vx_req_data),
        .vx_req_tag_i(vx_req_tag),
        .vx_rsp_valid_o(vx_rsp_valid), .vx_rsp_ready_i(vx_rsp_ready),
        .vx_rsp_data_o(vx_rsp_data), .vx_rsp_tag_o(vx_rsp_tag),
        .obi_req_o(obi_req), .obi_gnt_i(obi_gnt), .obi_we_o(obi_we),
        .obi_be_o(obi_be), .obi_addr_o(obi_addr), .obi_wdata_o(obi_wdata),
        .obi_rvalid_i(obi_rvalid), .obi_rdata_i(obi_rdata),
        .outstanding_o(outstanding), .protocol_err_o(protocol_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // inputs change 1 time unit after the rising edge; checks follow at +2
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        vx_req_valid = 0; vx_req_rw = 0; vx_req_byteen = 0; vx_req_addr = 0;
        vx_req_data = 0; vx_req_tag = 0; vx_rsp_ready = 0;
        obi_gnt = 0; obi_rvalid = 0; obi_rdata = 0;
        tick(); tick();
        settle();
        check("rst_ready", vx_req_ready, 0);
        check("rst_obi_req", obi_req, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_rsp_valid", vx_rsp_valid, 0);
        check("rst_err", protocol_err, 0);
        rst = 1'b0;
        tick();

        // single read
        vx_req_valid = 1; vx_req_rw = 0; vx_req_addr = 32'h100; vx_req_tag = 1; obi_gnt = 1;
        settle();
        check("rd_ready", vx_req_ready, 1);
        check("rd_occ0", outstanding, 0);
        tick();
        vx_req_valid = 0;
        settle();
        check("rd_obi_req", obi_req, 1);
        check("rd_obi_addr", obi_addr, 32'h100);
        check("rd_obi_we", obi_we, 0);
        check("rd_occ1", outstanding, 1);
        tick();
        check("rd_req_drop", obi_req, 0);
        tick();
        obi_rvalid = 1; obi_rdata = 32'hDEADBEEF;
        settle();
        check("rd_no_bypass", vx_rsp_valid, 0);
        tick();
        obi_rvalid = 0;
        settle();
        check("rd_rsp_valid", vx_rsp_valid, 1);
        check("rd_rsp_data", vx_rsp_data, 32'hDEADBEEF);
        check("rd_rsp_tag", vx_rsp_tag, 1);
        check("rd_occ_rsp", outstanding, 1);
        vx_rsp_ready = 1;
        tick();
        vx_rsp_ready = 0;
        settle();
        check("rd_rsp_done", vx_rsp_valid, 0);
        check("rd_occ_end", outstanding, 0);

        // single write
        vx_req_valid = 1; vx_req_rw = 1; vx_req_addr = 32'h200; vx_req_data = 32'h12345678;
        vx_req_byteen = 4'hF; vx_req_tag = 0;
        tick();
        vx_req_valid = 0;
        settle();
        check("wr_obi_req", obi_req, 1);
        check("wr_obi_we", obi_we, 1);
        check("wr_obi_addr", obi_addr, 32'h200);
        check("wr_obi_wdata", obi_wdata, 32'h12345678);
        check("wr_obi_be", obi_be, 4'hF);
        check("wr_occ1", outstanding, 1);
        tick();
        obi_rvalid = 1;
        tick();
        obi_rvalid = 0;
        settle();
        check("wr_no_rsp", vx_rsp_valid, 0);
        check("wr_occ0", outstanding, 0);

        // saturation: 6 reads offered, 4 accepted
        vx_req_rw = 0; vx_req_valid = 1;
        for (int i = 0; i < 6; i++) begin
            vx_req_addr = 32'h300 + 32'(i * 4);
            vx_req_tag  = 1'(i);
            settle();
            check("sat_ready", vx_req_ready, (i < 4) ? 1 : 0);
            check("sat_occ", outstanding, (i < 4) ? i : 4);
            tick();
        end
        vx_req_valid = 0;
        settle();
        check("sat_full_occ", outstanding, 4);
        check("sat_full_ready", vx_req_ready, 0);
        obi_rvalid = 1; obi_rdata = 32'hA0;
        tick();
        obi_rvalid = 0;
        settle();
        check("sat_rv_occ", outstanding, 4);
        check("sat_rv_ready", vx_req_ready, 0);
        check("sat_rv_data", vx_rsp_data, 32'hA0);
        check("sat_rv_tag", vx_rsp_tag, 0);
        tick();
        vx_rsp_ready = 1;
        settle();
        check("sat_hold_ready", vx_req_ready, 0);
        tick();
        vx_rsp_ready = 0;
        settle();
        check("sat_pop_occ", outstanding, 3);
        check("sat_pop_ready", vx_req_ready, 1);
        obi_rvalid = 1; obi_rdata = 32'hB1;
        tick();
        obi_rdata = 32'hB2;
        tick();
        obi_rdata = 32'hB3;
        tick();
        obi_rvalid = 0;
        settle();
        check("sat_drain_occ", outstanding, 3);
        vx_rsp_ready = 1;
        settle();
        check("sat_b1_data", vx_rsp_data, 32'hB1);
        check("sat_b1_tag", vx_rsp_tag, 1);
        tick();
        check("sat_b2_data", vx_rsp_data, 32'hB2);
        check("sat_b2_tag", vx_rsp_tag, 0);
        tick();
        check("sat_b3_data", vx_rsp_data, 32'hB3);
        check("sat_b3_tag", vx_rsp_tag, 1);
        tick();
        vx_rsp_ready = 0;
        settle();
        check("sat_end_valid", vx_rsp_valid, 0);
        check("sat_end_occ", outstanding, 0);

        // grant stall
        obi_gnt = 0;
        vx_req_valid = 1; vx_req_rw = 1; vx_req_addr = 32'h400; vx_req_data = 32'hCAFEF00D;
        vx_req_byteen = 4'h5; vx_req_tag = 1;
        settle();
        check("stall_first_ready", vx_req_ready, 1);
        tick();
        vx_req_addr = 32'h500; vx_req_data = 32'h0BADBEEF; vx_req_byteen = 4'h3;
        for (int i = 0; i < 5; i++) begin
            settle();
            check("stall_req", obi_req, 1);
            check("stall_addr", obi_addr, 32'h400);
            check("stall_wdata", obi_wdata, 32'hCAFEF00D);
            check("stall_we", obi_we, 1);
            check("stall_be", obi_be, 4'h5);
            check("stall_ready", vx_req_ready, 0);
            tick();
        end
        obi_gnt = 1;
        settle();
        check("stall_gnt_ready", vx_req_ready, 1);
        tick();
        vx_req_valid = 0;
        settle();
        check("stall_next_addr", obi_addr, 32'h500);
        check("stall_next_be", obi_be, 4'h3);
        check("stall_occ2", outstanding, 2);
        tick();
        check("stall_idle", obi_req, 0);
        obi_rvalid = 1;
        tick();
        check("stall_occ1", outstanding, 1);
        tick();
        obi_rvalid = 0;
        settle();
        check("stall_occ0", outstanding, 0);
        check("stall_no_rsp", vx_rsp_valid, 0);

        // ordering: read tag0, write, read tag1
        vx_req_valid = 1; vx_req_rw = 0; vx_req_addr = 32'h600; vx_req_tag = 0;
        tick();
        vx_req_rw = 1; vx_req_addr = 32'h604; vx_req_data = 32'h1;
        tick();
        vx_req_rw = 0; vx_req_addr = 32'h608; vx_req_tag = 1;
        tick();
        vx_req_valid = 0;
        settle();
        check("ord_occ3", outstanding, 3);
        check("ord_last_addr", obi_addr, 32'h608);
        tick();
        obi_rvalid = 1; obi_rdata = 32'h11;
        tick();
        obi_rdata = 32'h22;
        tick();
        obi_rdata = 32'h33;
        tick();
        obi_rvalid = 0;
        settle();
        check("ord_occ2", outstanding, 2);
        for (int i = 0; i < 3; i++) begin
            check("ord_hold_data", vx_rsp_data, 32'h11);
            tick();
        end
        vx_rsp_ready = 1;
        settle();
        check("ord_r0_data", vx_rsp_data, 32'h11);
        check("ord_r0_tag", vx_rsp_tag, 0);
        tick();
        check("ord_r1_valid", vx_rsp_valid, 1);
        check("ord_r1_data", vx_rsp_data, 32'h33);
        check("ord_r1_tag", vx_rsp_tag, 1);
        tick();
        vx_rsp_ready = 0;
        settle();
        check("ord_end_valid", vx_rsp_valid, 0);
        check("ord_end_occ", outstanding, 0);

        // stray rvalid
        obi_rvalid = 1; obi_rdata = 32'h55;
        tick();
        obi_rvalid = 0;
        settle();
        check("err_set", protocol_err, 1);
        check("err_occ", outstanding, 0);
        check("err_no_rsp", vx_rsp_valid, 0);
        tick(); tick();
        check("err_sticky", protocol_err, 1);

        // reset with 3 in flight
        vx_req_valid = 1; vx_req_rw = 1; vx_req_addr = 32'h700; vx_req_data = 32'hFFFF0000;
        vx_req_byteen = 4'hF;
        tick(); tick(); tick();
        vx_req_valid = 0;
        settle();
        check("rst2_pre_occ", outstanding, 3);
        rst = 1'b1;
        settle();
        check("rst2_ready", vx_req_ready, 0);
        check("rst2_obi_req", obi_req, 0);
        check("rst2_addr", obi_addr, 0);
        check("rst2_wdata", obi_wdata, 0);
        check("rst2_we", obi_we, 0);
        check("rst2_be", obi_be, 0);
        check("rst2_occ", outstanding, 0);
        check("rst2_err", protocol_err, 0);
        check("rst2_rsp_valid", vx_rsp_valid, 0);
        check("rst2_rsp_data", vx_rsp_data, 0);
        tick();
        rst = 1'b0;
        tick();
        obi_rvalid = 1;
        tick();
        obi_rvalid = 0;
        settle();
        check("rst2_stray_err", protocol_err, 1);
        check("rst2_stray_occ", outstanding, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/obi_bridge_pipelined.md
Name: obi_bridge_pipelined

Overview:
- Parametrised successor of the single-transaction VX-to-OBI bridge. Converts the Vortex memory request/response handshake into OBI master transactions.
- Keeps up to MAX_OUTSTANDING transactions in flight and returns read responses in order, with each response carrying its VX tag.
- Sits between a Vortex core/cache memory port and the OBI interconnect. Write completions are absorbed and never returned to VX.

Parameters:
- TAG_WIDTH_BIT, 1, width of VX request/response tag
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; must be a multiple of 8
- MAX_OUTSTANDING, 4, maximum accepted-but-not-completed transactions, including buffered read responses; power of two, ≥2

Ports:
- clk_i  input  1  clock
- rst_i  input  1  asynchronous active-high reset
- vx_req_valid_i  input  1  VX request valid
- vx_req_ready_o  output  1  VX request accepted this cycle
- vx_req_rw_i  input  1  1=write, 0=read
- vx_req_byteen_i  input  DATA_WIDTH/8  byte enables
- vx_req_addr_i  input  ADDR_WIDTH  address
- vx_req_data_i  input  DATA_WIDTH  write data
- vx_req_tag_i  input  TAG_WIDTH_BIT  request tag
- vx_rsp_valid_o  output  1  read response valid
- vx_rsp_ready_i  input  1  VX accepts response
- vx_rsp_data_o  output  DATA_WIDTH  read data
- vx_rsp_tag_o  output  TAG_WIDTH_BIT  tag of the original read
- obi_req_o  output  1  OBI request
- obi_gnt_i  input  1  OBI grant
- obi_we_o  output  1  OBI write enable
- obi_be_o  output  DATA_WIDTH/8  OBI byte enables
- obi_addr_o  output  ADDR_WIDTH  OBI address
- obi_wdata_o  output  DATA_WIDTH  OBI write data
- obi_rvalid_i  input  1  OBI response valid
- obi_rdata_i  input  DATA_WIDTH  OBI read data
- outstanding_o  output  $clog2(MAX_OUTSTANDING+1)  current occupancy count
- protocol_err_o  output  1  sticky: rvalid received with nothing outstanding

Behaviour:
- Reset: one clock, clk_i; reset rst_i asynchronous active-high. While reset is asserted:
  - all outputs are 0;
  - all FIFOs are emptied, counters are zero, the request register is invalid;
  - transactions in flight are discarded; a later stray rvalid is flagged via protocol_err_o.
- Request register: one entry (req_q). obi_req_o = req_q valid. obi_we/be/addr/wdata come directly from req_q and are stable while obi_req_o=1 and gnt=0.
- Pending FIFO: depth MAX_OUTSTANDING, entries {rw, tag}.
- Response FIFO: depth MAX_OUTSTANDING, entries {rdata, tag}; vx_rsp_* driven from its head.
- Occupancy = pending FIFO entries + response FIFO entries; reported on outstanding_o.
- Accept rule: vx_req_ready_o = (occupancy < MAX_OUTSTANDING) && (!req_q valid || obi_gnt_i). This is combinational from obi_gnt_i; it has no combinational dependency on vx_req_valid_i.
- On accept (valid && ready):
  - req_q is loaded;
  - {rw, tag} is pushed to the pending FIFO;
  - occupancy +1.
  - Accept at cycle N gives obi_req_o=1 at N+1. Back-to-back accepts (one per cycle) are sustained while gnt=1 and occupancy permits.
- On grant (obi_req_o && obi_gnt_i) with no new accept: req_q becomes invalid next cycle.
- On obi_rvalid_i: pop the pending FIFO head.
  - Read head: push {obi_rdata_i, head tag} to the response FIFO; occupancy unchanged.
  - Write head: entry dropped; occupancy −1.
  - The response FIFO can never overflow by construction.
- Response latency: rvalid at cycle M gives vx_rsp_valid_o=1 at M+1 (registered FIFO, no bypass). Responses leave in OBI completion order, which equals request order.
- On vx_rsp_valid_o && vx_rsp_ready_i: pop the response FIFO; occupancy −1.
- Simultaneous events in one cycle (accept, write-completion drop, response pop) are combined: occupancy changes by +1 for an accept, −1 per retirement, net. A full FIFO that pops and pushes in the same cycle stays full.
- rvalid while the pending FIFO is empty: event ignored (no push, no pop); protocol_err_o set to 1 and held until reset.
- obi_rvalid_i is never back-pressured. OBI may return rvalid the cycle after gnt, or later.
- FIFO pointers are $clog2(MAX_OUTSTANDING) bits wide, wrap modulo depth, and carry an extra wrap bit for full/empty.

Test Plan:
- Single read: addr 0x100, tag 1; gnt same cycle as req; rvalid 2 cycles later with rdata 0xDEADBEEF → vx_rsp_valid 1 cycle after rvalid, data 0xDEADBEEF, tag 1; outstanding_o returns to 0.
- Single write: addr 0x200, data 0x12345678, be 0xF → obi_we_o=1 with those values; rvalid produces no vx_rsp_valid; outstanding_o 1→0.
- Saturation: MAX_OUTSTANDING=4, gnt always 1, rvalid withheld, 6 reads offered → exactly 4 accepted; vx_req_ready_o=0 with outstanding_o=4; first rvalid leaves occupancy at 4 and ready stays 0 until vx_rsp_ready_i=1 pops one.
- Grant stall: gnt=0 for 5 cycles → obi_req_o held with addr/data/we/be stable; vx_req_ready_o=0 while req_q is valid.
- Ordering/mix: read tag0, write, read tag1 issued back-to-back; rvalids in consecutive cycles; vx_rsp_ready_i=0 for 3 cycles then 1 → responses are tag0 then tag1 with matching data and no write response.
- Errors and reset: rvalid with nothing outstanding → protocol_err_o=1 sticky. Reset asserted with 3 transactions in flight → all outputs 0 and outstanding_o=0; protocol_err_o cleared.
